// File: rtl/up_apb3_slave.sv
// rtl/up_apb3_slave.sv - APB3 completer bridging single transfers onto the uP register req/ack handshake.
// Optional REQ timeout with slave error: UP_APB3_TIMEOUT_EN.
module up_apb3_slave #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  localparam int DW  = BUS_WIDTH * 8,
  localparam int OFF = $clog2(BUS_WIDTH),
  localparam int AW  = ADDRESS_WIDTH - OFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] s_apb_paddr,
  input  logic                     s_apb_psel,
  input  logic                     s_apb_penable,
  output logic                     s_apb_pready,
  input  logic                     s_apb_pwrite,
  input  logic [DW-1:0]            s_apb_pwdata,
  output logic [DW-1:0]            s_apb_prdata,
  output logic                     s_apb_pslverror,
  output logic                     up_rreq,
  input  logic                     up_rack,
  output logic [AW-1:0]            up_raddr,
  input  logic [DW-1:0]            up_rdata,
  output logic                     up_wreq,
  input  logic                     up_wack,
  output logic [AW-1:0]            up_waddr,
  output logic [DW-1:0]            up_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             dir_write;
  logic [AW-1:0]    word_addr;
  logic             ack_hit;
  logic             unused_paddr;

  // Byte-offset bits are dropped; the decoder only sees word addresses.
  assign word_addr    = s_apb_paddr[ADDRESS_WIDTH-1:OFF];
  assign unused_paddr = ^s_apb_paddr;
  assign ack_hit      = dir_write ? up_wack : up_rack;

`ifdef UP_APB3_TIMEOUT_EN
  logic [15:0] tmo_cnt;
`else
  assign s_apb_pslverror = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      dir_write    <= 1'b0;
      s_apb_pready <= 1'b0;
      s_apb_prdata <= '0;
      up_rreq      <= 1'b0;
      up_wreq      <= 1'b0;
      up_raddr     <= '0;
      up_waddr     <= '0;
      up_wdata     <= '0;
`ifdef UP_APB3_TIMEOUT_EN
      s_apb_pslverror <= 1'b0;
      tmo_cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          s_apb_pready <= 1'b0;
          if (s_apb_psel && !s_apb_penable) begin
            dir_write <= s_apb_pwrite;
            if (s_apb_pwrite) begin
              up_waddr <= word_addr;
              up_wdata <= s_apb_pwdata;
              up_wreq  <= 1'b1;
            end else begin
              up_raddr <= word_addr;
              up_rreq  <= 1'b1;
            end
`ifdef UP_APB3_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state <= REQ;
          end
        end

        REQ: begin
          if (ack_hit) begin
            up_wreq      <= 1'b0;
            up_rreq      <= 1'b0;
            if (!dir_write) begin
              s_apb_prdata <= up_rdata;
            end
            s_apb_pready <= 1'b1;
            state        <= RESP;
          end
`ifdef UP_APB3_TIMEOUT_EN
          // 65535 REQ cycles without an ack: abandon the request with an error.
          else if (tmo_cnt == 16'hFFFE) begin
            up_wreq         <= 1'b0;
            up_rreq         <= 1'b0;
            s_apb_prdata    <= '0;
            s_apb_pready    <= 1'b1;
            s_apb_pslverror <= 1'b1;
            state           <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        RESP: begin
          s_apb_pready <= 1'b0;
`ifdef UP_APB3_TIMEOUT_EN
          s_apb_pslverror <= 1'b0;
`endif
          state <= IDLE;
        end

        default: begin
          s_apb_pready <= 1'b0;
          up_wreq      <= 1'b0;
          up_rreq      <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_apb3_slave.sv
// tb/tb_up_apb3_slave.sv - Self-checking bench for up_apb3_slave.
module tb_up_apb3_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic        pready, pslverror;
  logic [31:0] prdata;
  logic        rreq, rack, wreq, wack;
  logic [13:0] raddr, waddr;
  logic [31:0] rdata, wdata;

  always #5 clk = ~clk;

  up_apb3_slave #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
    .s_apb_pready(pready), .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
    .s_apb_prdata(prdata), .s_apb_pslverror(pslverror),
    .up_rreq(rreq), .up_rack(rack), .up_raddr(raddr), .up_rdata(rdata),
    .up_wreq(wreq), .up_wack(wack), .up_waddr(waddr), .up_wdata(wdata)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          dly;
    bit          drop;
    logic [13:0] exp_addr;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          passed = 0;
  int          popped = 0;
  logic [31:0] last_rd = '0;
  vec_t        vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every request/ack pair seen on the uP side consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if ((wreq === 1'b1 && wack === 1'b1) || (rreq === 1'b1 && rack === 1'b1)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          popped++;
          check("sb_dir", {31'd0, wreq}, {31'd0, e.wr});
          check("sb_addr", e.wr ? {18'd0, waddr} : {18'd0, raddr}, {18'd0, e.addr});
          if (e.wr) check("sb_wdata", wdata, e.data);
        end
      end
    end
  end

  task automatic xfer(input vec_t v);
    @(negedge clk);
    exp_q.push_back('{wr: v.wr, addr: v.exp_addr, data: v.wdat});
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdat;
    @(posedge clk); #1;
    check("req_wr", {31'd0, wreq}, {31'd0, v.wr});
    check("req_rd", {31'd0, rreq}, {31'd0, !v.wr});
    check("req_addr", v.wr ? {18'd0, waddr} : {18'd0, raddr}, {18'd0, v.exp_addr});
    if (v.wr) check("req_wdata", wdata, v.wdat);
    check("pready_in_req", {31'd0, pready}, 32'd0);
    @(negedge clk);
    if (v.drop) begin psel = 1'b0; penable = 1'b0; end
    else penable = 1'b1;
    pwdata = ~v.wdat; paddr = ~v.addr;
    for (int i = 0; i < v.dly; i++) begin
      if (v.wr) rack = 1'b1; else wack = 1'b1;
      @(posedge clk); #1;
      check("wait_req", {31'd0, v.wr ? wreq : rreq}, 32'd1);
      check("wait_addr", v.wr ? {18'd0, waddr} : {18'd0, raddr}, {18'd0, v.exp_addr});
      check("wait_pready", {31'd0, pready}, 32'd0);
      @(negedge clk);
    end
    rack = 1'b0; wack = 1'b0;
    if (v.wr) wack = 1'b1;
    else begin rack = 1'b1; rdata = v.rdat; end
    #1 check("req_in_ack_cycle", {31'd0, v.wr ? wreq : rreq}, 32'd1);
    @(posedge clk); #1;
    check("pready_pulse", {31'd0, pready}, 32'd1);
    check("req_dropped", {30'd0, wreq, rreq}, 32'd0);
    check("pslverror", {31'd0, pslverror}, 32'd0);
    if (!v.wr) last_rd = v.rdat;
    check("prdata", prdata, last_rd);
    wack = 1'b0; rack = 1'b0; rdata = $urandom;
    @(posedge clk); #1;
    check("pready_single", {31'd0, pready}, 32'd0);
    check("prdata_hold", prdata, last_rd);
    check("no_req_after", {30'd0, wreq, rreq}, 32'd0);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    vecs[0]  = '{1, 16'h000C, 32'hAAAADEAD, 32'h0,        1, 0, 14'h0003};
    vecs[1]  = '{0, 16'h0008, 32'h0,        32'hB0BDBEEF, 1, 0, 14'h0002};
    vecs[2]  = '{1, 16'h0010, 32'h11223344, 32'h0,        5, 0, 14'h0004};
    vecs[3]  = '{0, 16'h0014, 32'h0,        32'hCAFEF00D, 5, 0, 14'h0005};
    vecs[4]  = '{1, 16'h0000, 32'h00000010, 32'h0,        0, 0, 14'h0000};
    vecs[5]  = '{1, 16'h0004, 32'h00000011, 32'h0,        0, 0, 14'h0001};
    vecs[6]  = '{1, 16'h0008, 32'h00000012, 32'h0,        0, 0, 14'h0002};
    vecs[7]  = '{1, 16'h000C, 32'h00000013, 32'h0,        0, 0, 14'h0003};
    vecs[8]  = '{0, 16'h000F, 32'h0,        32'h12345678, 0, 0, 14'h0003};
    vecs[9]  = '{1, 16'hFFFC, 32'h5A5A5A5A, 32'h0,        2, 1, 14'h3FFF};
    vecs[10] = '{0, 16'h0020, 32'h0,        32'h00000000, 0, 0, 14'h0008};

    rst = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004;
    pwdata = 32'hFFFFFFFF; rack = 1'b0; wack = 1'b0; rdata = 32'hDEADBEEF;
    ok = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if ((|{pready, pslverror, rreq, wreq, prdata, raddr, waddr, wdata}) !== 1'b0) ok = 1'b0;
    end
    check("reset_hold_all_zero", {31'd0, ok}, 32'd1);
    @(negedge clk); psel = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {29'd0, wreq, rreq, pready}, 32'd0);

    for (int i = 0; i < 11; i++) xfer(vecs[i]);

`ifdef UP_APB3_TIMEOUT_EN
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0040; rdata = 32'h77777777;
    @(posedge clk); #1;
    check("tmo_req", {31'd0, rreq}, 32'd1);
    @(negedge clk); penable = 1'b1;
    n = 0;
    while (pready !== 1'b1 && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_cycles", n, 65535);
    check("tmo_pready", {31'd0, pready}, 32'd1);
    check("tmo_pslverror", {31'd0, pslverror}, 32'd1);
    check("tmo_prdata", prdata, 32'd0);
    check("tmo_rreq", {31'd0, rreq}, 32'd0);
    @(negedge clk); rack = 1'b1;
    @(posedge clk); #1;
    check("tmo_pready_single", {30'd0, pready, pslverror}, 32'd0);
    @(posedge clk); #1;
    check("late_ack_ignored", {31'd0, pready}, 32'd0);
    check("late_ack_prdata", prdata, 32'd0);
    rack = 1'b0; psel = 1'b0; penable = 1'b0;
`else
    n = 0;
    xfer('{0, 16'h0040, 32'h0, 32'h0BADCAFE, 300, 0, 14'h0010});
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
`ifdef UP_APB3_TIMEOUT_EN
    check("sb_count", popped, 11);
`else
    check("sb_count", popped, 12);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/up_apb3_slave.md
Name: up_apb3_slave

Overview:
- APB3 completer that converts single APB3 transfers into the codebase's uP register request/acknowledge handshake.
- Sits between a system APB3 interconnect and a peripheral's register decoder, which sees word addresses, read/write request strobes and ack inputs.
- One outstanding transfer at a time; wait states are inserted via s_apb_pready until the uP side acknowledges.

Parameters:
- ADDRESS_WIDTH, 16, width of s_apb_paddr in bits (byte address).
- BUS_WIDTH, 4, data bus width in bytes; data width DW = BUS_WIDTH*8; power of two, at least 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low.
- s_apb_paddr  in  ADDRESS_WIDTH  APB byte address.
- s_apb_psel  in  1  completer select.
- s_apb_penable  in  1  access phase.
- s_apb_pready  out  1  transfer complete.
- s_apb_pwrite  in  1  1 = write, 0 = read.
- s_apb_pwdata  in  DW  write data.
- s_apb_prdata  out  DW  read data.
- s_apb_pslverror  out  1  transfer error.
- up_rreq  out  1  read request, held until ack.
- up_rack  in  1  read acknowledge; up_rdata valid.
- up_raddr  out  AW  read word address, AW = ADDRESS_WIDTH - log2(BUS_WIDTH).
- up_rdata  in  DW  read data.
- up_wreq  out  1  write request, held until ack.
- up_wack  in  1  write acknowledge.
- up_waddr  out  AW  write word address.
- up_wdata  out  DW  write data.

Behaviour:
- Reset (rst low at an edge): state IDLE; s_apb_pready, s_apb_prdata, s_apb_pslverror, up_rreq, up_wreq, up_raddr, up_waddr and up_wdata all 0. Reset aborts any transfer in flight.
- Word address = s_apb_paddr >> log2(BUS_WIDTH); the low byte-offset bits are ignored.
- IDLE:
  - When psel=1 and penable=0 (setup phase) is sampled, latch address and direction; for writes also latch pwdata.
  - Go to REQ and assert up_wreq or up_rreq from the next cycle.
  - The request address/data outputs are registered and stable for the whole request.
- REQ:
  - The request stays high until the matching ack (up_wack for writes, up_rack for reads) is sampled high. The request is therefore still high during the cycle the ack is high.
  - At that edge: drop the request; for reads, register up_rdata into s_apb_prdata; pulse s_apb_pready for exactly one cycle; go to RESP.
  - Acks of the other direction are ignored.
- RESP:
  - s_apb_pready=1 for one cycle, then return to IDLE.
  - s_apb_prdata holds its last value until the next read completes.
- Latency:
  - Setup sampled at edge k; request visible after edge k.
  - Ack sampled at edge k+n (n ≥ 1) gives pready high after edge k+n for one cycle.
  - Minimum transfer: setup + 2 access cycles.
- s_apb_pready is low in every state other than RESP.
- Back-to-back: a new setup is accepted from IDLE only, i.e. on the cycle after the pready pulse at the earliest.
- If psel drops mid-transfer, the uP request still completes, and the pready pulse is still generated and ignored by the master.
- No byte strobes (APB3); all writes are full-word.
- s_apb_pslverror is 0 unless the optional feature below is enabled.

Optional Feature:
- Macro: UP_APB3_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in REQ.
  - If no ack arrives within 65535 cycles: drop the request, set s_apb_prdata=0, and assert s_apb_pready and s_apb_pslverror together for one cycle.
  - A late ack arriving after the timeout is ignored.
- Undefined: no counter; REQ waits indefinitely and s_apb_pslverror is tied 0.

Test Plan:
- Reset: hold rst low for 25 cycles with psel=1 → all outputs 0 and no request during reset.
- Single write: paddr=0x000C, pwdata=0xAAAADEAD; responder acks one cycle after up_wreq → up_waddr=0x0003, up_wdata=0xAAAADEAD, wreq high through the ack cycle, one pready pulse, pslverror=0.
- Single read: paddr=0x0008; responder returns 0xB0BDBEEF with rack one cycle after rreq → up_raddr=0x0002, prdata=0xB0BDBEEF in the pready cycle.
- Wait states: ack delayed 5 cycles → request held steady, pready low throughout, then exactly one pready pulse.
- Streaming writes: paddr incrementing by 4 from 0, each restarted on the cycle after pready → up_waddr sequence 0,1,2,3, each with exactly one request/ack pair and no lost or duplicated transfers.
- With UP_APB3_TIMEOUT_EN: read with no ack → pready=1, pslverror=1, prdata=0 after 65535 cycles; rreq then low. Without the macro the bench observes pready stays low.
